acl_tilt_controller: RTL and testbench

//  - Parametrised ADXL362 SPI controller for the Temple Run game, built for the next generation of the game's accelerometer interface.
//  - Configures the sensor once after reset, then burst-reads 1..3 axes of 8-bit data at a fixed sample rate.
//  - Outputs the raw axis bytes plus a debounced, hysteretic X-tilt lane command for the game logic.

---
 rtl/acl_tilt_controller.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_acl_tilt_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_tilt_controller.sv
// -----------------------------------------------------------------------------
// acl_tilt_controller
//   ADXL362 SPI controller. After reset it writes POWER_CTL = measure once and
//   then burst-reads NUM_AXES bytes (X, Y, Z) every SAMPLE_PERIOD clocks.
//   The X byte drives a hysteretic tilt decoder that produces the lane command.
//
//   Optional build macro: ACL_AVG4_EN - each axis becomes the arithmetic mean
//   of the last four raw samples. The history is cleared by reset, and the tilt
//   decoder uses the averaged X.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   miso        in   SPI data from sensor
//   sclk        out  SPI clock, mode 0 (idle low)
//   mosi        out  SPI data to sensor, MSB first
//   cs_n        out  SPI chip select, active low
//   axis_data   out  latest sample, byte k = axis k, X in [7:0]
//   data_valid  out  one-cycle pulse when axis_data updates
//   tilt_dir    out  00 centre, 01 left, 10 right
//   busy        out  high while cs_n is low
// -----------------------------------------------------------------------------
module acl_tilt_controller #(
    parameter int CLK_DIV       = 13,
    parameter int NUM_AXES      = 3,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int TILT_THRESH   = 32,
    parameter int TILT_HYST     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic [NUM_AXES*8-1:0] axis_data,
    output logic                  data_valid,
    output logic [1:0]            tilt_dir,
    output logic                  busy
);

    localparam int FRAME_W = (2 + NUM_AXES) * 8;
    localparam int RX_W    = NUM_AXES * 8;
    localparam int CFG_W   = 24;
    localparam int HALF_W  = $clog2(2 * FRAME_W + 1);
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int PER_W   = $clog2(SAMPLE_PERIOD + 1);

    // Frames are left-aligned so the MSB of the shifter is always the bit on the wire
    localparam logic [FRAME_W-1:0] CFG_FRAME  = FRAME_W'(24'h0A2D02) << (FRAME_W - CFG_W);
    localparam logic [FRAME_W-1:0] READ_FRAME = FRAME_W'(16'h0B08) << (FRAME_W - 16);

    localparam logic [1:0] TILT_CENTRE = 2'b00;
    localparam logic [1:0] TILT_LEFT   = 2'b01;
    localparam logic [1:0] TILT_RIGHT  = 2'b10;

    localparam logic signed [8:0] TH_P = 9'(TILT_THRESH);
    localparam logic signed [8:0] TH_N = 9'(-TILT_THRESH);
    localparam logic signed [8:0] XR_P = 9'(TILT_THRESH - TILT_HYST);
    localparam logic signed [8:0] XR_N = 9'(TILT_HYST - TILT_THRESH);

    typedef enum logic [2:0] {
        S_CFG    = 3'd0,
        S_GAP    = 3'd1,
        S_WAIT   = 3'd2,
        S_READ   = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [HALF_W-1:0]     r_half_cnt;
    logic [PER_W-1:0]      r_period_cnt;
    logic [FRAME_W-1:0]    r_tx_shift;
    logic [RX_W-1:0]       r_rx_shift;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_busy;
    logic [RX_W-1:0]       r_axis_data;
    logic                  r_data_valid;
    logic [1:0]            r_tilt;

    logic                  w_xfer;
    logic                  w_div_end;
    logic                  w_gap_end;
    logic                  w_period_due;
    logic                  w_xfer_done;
    logic                  w_read_entry;
    logic [HALF_W-1:0]     w_last_half;
    logic [RX_W-1:0]       w_axis_raw;
    logic [RX_W-1:0]       w_axis_new;
    logic signed [8:0]     w_x9;
    logic [1:0]            w_tilt_nxt;

    // Half-period 0 is the cs_n setup, odd halves have SCLK high, even halves SCLK low;
    // the final low half doubles as the cs_n hold time.
    assign w_xfer       = (r_state == S_CFG) || (r_state == S_READ);
    assign w_last_half  = (r_state == S_CFG) ? HALF_W'(2 * CFG_W) : HALF_W'(2 * FRAME_W);
    assign w_div_end    = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_gap_end    = (r_div_cnt == DIV_W'(2 * CLK_DIV - 1));
    assign w_period_due = (r_period_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign w_xfer_done  = w_div_end && (r_half_cnt == w_last_half);
    assign w_read_entry = (w_state_nxt == S_READ) && (r_state != S_READ);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CFG:    if (w_xfer_done) w_state_nxt = S_GAP;    else w_state_nxt = S_CFG;
            S_READ:   if (w_xfer_done) w_state_nxt = S_UPDATE; else w_state_nxt = S_READ;
            S_UPDATE: w_state_nxt = S_GAP;
            S_GAP:    if (w_gap_end) w_state_nxt = S_WAIT;     else w_state_nxt = S_GAP;
            S_WAIT:   if (w_period_due) w_state_nxt = S_READ;  else w_state_nxt = S_WAIT;
            default:  w_state_nxt = S_CFG;
        endcase
    end

    // Half-period and gap timing counters, cleared on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
        end else if (w_xfer) begin
            if (w_div_end) begin
                r_div_cnt  <= '0;
                r_half_cnt <= r_half_cnt + HALF_W'(1);
            end else begin
                r_div_cnt  <= r_div_cnt + DIV_W'(1);
            end
        end else if (r_state == S_GAP) begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end else begin
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
        end
    end

    // Sample-period counter: zero at READ entry, saturates so an overrun READ restarts at once.
    // Reset value is saturated so the first READ follows the configuration gap directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_cnt <= PER_W'(SAMPLE_PERIOD - 1);
        end else if (w_read_entry) begin
            r_period_cnt <= '0;
        end else if (!w_period_due) begin
            r_period_cnt <= r_period_cnt + PER_W'(1);
        end else begin
            r_period_cnt <= r_period_cnt;
        end
    end

    // MOSI shifter: advances at the end of each SCLK-high half so the next bit appears on the fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_shift <= CFG_FRAME;
        end else if (w_read_entry) begin
            r_tx_shift <= READ_FRAME;
        end else if (w_xfer && w_div_end && r_half_cnt[0]) begin
            r_tx_shift <= r_tx_shift << 1;
        end else begin
            r_tx_shift <= r_tx_shift;
        end
    end

    // MISO capture on the edge that raises SCLK; the command bytes fall off the top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_shift <= '0;
        end else if ((r_state == S_READ) && r_half_cnt[0] && (r_div_cnt == '0)) begin
            r_rx_shift <= {r_rx_shift[RX_W-2:0], miso};
        end else begin
            r_rx_shift <= r_rx_shift;
        end
    end

`ifdef ACL_AVG4_EN
    logic [7:0]        r_hist [NUM_AXES][3];
    logic signed [9:0] w_sum  [NUM_AXES];

    // Raw-sample history for the 4-tap running mean
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_AXES; k++) begin
                for (int d = 0; d < 3; d++) begin
                    r_hist[k][d] <= 8'h00;
                end
            end
        end else if (r_state == S_UPDATE) begin
            for (int k = 0; k < NUM_AXES; k++) begin
                r_hist[k][0] <= w_axis_raw[k*8 +: 8];
                r_hist[k][1] <= r_hist[k][0];
                r_hist[k][2] <= r_hist[k][1];
            end
        end else begin
            r_hist <= r_hist;
        end
    end
`endif

    // Reorder captured bytes so X lands in [7:0], then optionally average
    always_comb begin
        w_axis_raw = '0;
        w_axis_new = '0;
        for (int k = 0; k < NUM_AXES; k++) begin
            w_axis_raw[k*8 +: 8] = r_rx_shift[(NUM_AXES-1-k)*8 +: 8];
`ifdef ACL_AVG4_EN
            w_sum[k] = 10'($signed(w_axis_raw[k*8 +: 8])) + 10'($signed(r_hist[k][0]))
                     + 10'($signed(r_hist[k][1])) + 10'($signed(r_hist[k][2]));
            w_axis_new[k*8 +: 8] = w_sum[k][9:2];
`else
            w_axis_new[k*8 +: 8] = w_axis_raw[k*8 +: 8];
`endif
        end
    end

    assign w_x9 = $signed({w_axis_new[7], w_axis_new[7:0]});

    // Hysteretic tilt decode; opposite extreme jumps directly across
    always_comb begin
        w_tilt_nxt = r_tilt;
        case (r_tilt)
            TILT_CENTRE: begin
                if (w_x9 >= TH_P)      w_tilt_nxt = TILT_RIGHT;
                else if (w_x9 <= TH_N) w_tilt_nxt = TILT_LEFT;
                else                   w_tilt_nxt = TILT_CENTRE;
            end
            TILT_RIGHT: begin
                if (w_x9 <= TH_N)      w_tilt_nxt = TILT_LEFT;
                else if (w_x9 < XR_P)  w_tilt_nxt = TILT_CENTRE;
                else                   w_tilt_nxt = TILT_RIGHT;
            end
            TILT_LEFT: begin
                if (w_x9 >= TH_P)      w_tilt_nxt = TILT_RIGHT;
                else if (w_x9 > XR_N)  w_tilt_nxt = TILT_CENTRE;
                else                   w_tilt_nxt = TILT_LEFT;
            end
            default: w_tilt_nxt = TILT_CENTRE;
        endcase
    end

    // Registered outputs; async reset forces the bus idle within the reset cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_data_valid <= 1'b0;
            r_axis_data  <= '0;
            r_tilt       <= TILT_CENTRE;
        end else begin
            r_cs_n       <= !w_xfer;
            r_busy       <= w_xfer;
            r_sclk       <= w_xfer && r_half_cnt[0];
            r_mosi       <= w_xfer && r_tx_shift[FRAME_W-1];
            r_data_valid <= (r_state == S_UPDATE);
            if (r_state == S_UPDATE) begin
                r_axis_data <= w_axis_new;
                r_tilt      <= w_tilt_nxt;
            end else begin
                r_axis_data <= r_axis_data;
                r_tilt      <= r_tilt;
            end
        end
    end

    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign cs_n       = r_cs_n;
    assign busy       = r_busy;
    assign axis_data  = r_axis_data;
    assign data_valid = r_data_valid;
    assign tilt_dir   = r_tilt;

endmodule

// File: tb/tb_acl_tilt_controller.sv
// -----------------------------------------------------------------------------
// tb_acl_tilt_controller
//   Self-checking bench: an ADXL362 slave model serves queued samples, a small
//   reference model pushes expected axis/tilt words at each read start, and the
//   data_valid monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_acl_tilt_controller;

    localparam int CLK_DIV       = 2;
    localparam int NUM_AXES      = 3;
    localparam int SAMPLE_PERIOD = 200;
    localparam int TH            = 32;
    localparam int HYST          = 8;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } samp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        miso  = 1'b0;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [23:0] axis_data;
    logic        data_valid;
    logic [1:0]  tilt_dir;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int n_dv  = 0;

    acl_tilt_controller #(
        .CLK_DIV      (CLK_DIV),
        .NUM_AXES     (NUM_AXES),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .TILT_THRESH  (TH),
        .TILT_HYST    (HYST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .axis_data (axis_data),
        .data_valid(data_valid),
        .tilt_dir  (tilt_dir),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    samp_t       stim_q[$];
    logic [25:0] exp_q[$];
    int          m_tilt = 0;
    int          m_hist[3][3];

    task automatic model_clear();
        m_tilt = 0;
        for (int a = 0; a < 3; a++)
            for (int d = 0; d < 3; d++)
                m_hist[a][d] = 0;
    endtask

    task automatic model_push(input samp_t s);
        logic [7:0] raw[3];
        logic [7:0] res[3];
        int         x;
        raw[0] = s.x; raw[1] = s.y; raw[2] = s.z;
        for (int a = 0; a < 3; a++) begin
`ifdef ACL_AVG4_EN
            int sum;
            sum = int'($signed(raw[a])) + m_hist[a][0] + m_hist[a][1] + m_hist[a][2];
            res[a] = 8'(sum >>> 2);
            m_hist[a][2] = m_hist[a][1];
            m_hist[a][1] = m_hist[a][0];
            m_hist[a][0] = int'($signed(raw[a]));
`else
            res[a] = raw[a];
`endif
        end
        x = int'($signed(res[0]));
        case (m_tilt)
            0: if (x >= TH) m_tilt = 2; else if (x <= -TH) m_tilt = 1;
            2: if (x <= -TH) m_tilt = 1; else if (x < TH - HYST) m_tilt = 0;
            1: if (x >= TH) m_tilt = 2; else if (x > -(TH - HYST)) m_tilt = 0;
            default: m_tilt = 0;
        endcase
        exp_q.push_back({2'(m_tilt), res[2], res[1], res[0]});
    endtask

    // ---------------- SPI slave model ----------------
    logic [39:0] s_stream = '0;
    logic [39:0] s_rx     = '0;
    int          s_bits   = 0;
    bit          s_is_cfg = 1'b1;
    bit          s_abort  = 1'b0;
    bit          have_last = 1'b0;
    time         last_rd  = 0;

    always @(negedge cs_n) begin
        samp_t s;
        s_bits = 0;
        s_rx   = '0;
        if (!s_is_cfg) begin
            if (stim_q.size() > 0) s = stim_q.pop_front();
            else                   s = '0;
            s_stream = {16'h0000, s.x, s.y, s.z};
            model_push(s);
            if (have_last) check_value("read_period", 40'(($time - last_rd) / 10), 40'(SAMPLE_PERIOD));
            last_rd   = $time;
            have_last = 1'b1;
        end else begin
            s_stream = '0;
        end
        miso = s_stream[39];
    end

    always @(posedge sclk) begin
        if (cs_n === 1'b0) begin
            s_rx = {s_rx[38:0], mosi};
            s_bits++;
            check_value("busy_xfer", 40'(busy), 40'd1);
        end
    end

    always @(negedge sclk) begin
        if ((cs_n === 1'b0) && (s_bits < 40)) miso = s_stream[39 - s_bits];
    end

    always @(posedge cs_n) begin
        if (reset || s_abort) begin
            s_abort = 1'b0;
        end else if (s_is_cfg) begin
            check_value("cfg_bits", 40'(s_bits), 40'd24);
            check_value("cfg_mosi", 40'(s_rx[23:0]), 40'h0A2D02);
            check_value("pre_upd_axis", 40'(axis_data), 40'd0);
            check_value("pre_upd_tilt", 40'(tilt_dir), 40'd0);
            s_is_cfg = 1'b0;
        end else begin
            check_value("rd_bits", 40'(s_bits), 40'd40);
            check_value("rd_cmd", 40'(s_rx[39:24]), 40'h0B08);
        end
    end

    // ---------------- scoreboard pop on data_valid ----------------
    logic dv_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset && data_valid) begin
            logic [25:0] e;
            if (exp_q.size() == 0) begin
                check_value("dv_unexpected", 40'd1, 40'd0);
            end else begin
                e = exp_q.pop_front();
                check_value("axis_data", 40'(axis_data), 40'(e[23:0]));
                check_value("tilt_dir", 40'(tilt_dir), 40'(e[25:24]));
            end
            check_value("dv_pulse", 40'(dv_prev), 40'd0);
            check_value("busy_upd", 40'(busy), 40'd0);
            n_dv++;
        end
        dv_prev = data_valid;
    end

    task automatic wait_dv(input int target, input int budget);
        for (int i = 0; i < budget && n_dv < target; i++) @(posedge clk);
        check_value("dv_count", 40'(n_dv), 40'(target));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        model_clear();
        stim_q.push_back('{8'h40, 8'h10, 8'hF0});
        stim_q.push_back('{8'h20, 8'h11, 8'h22});
        stim_q.push_back('{8'h1A, 8'h33, 8'h44});
        stim_q.push_back('{8'h17, 8'h55, 8'h66});
        stim_q.push_back('{8'hE0, 8'h77, 8'h88});
        stim_q.push_back('{8'h19, 8'h99, 8'hAA});
        stim_q.push_back('{8'h80, 8'hBB, 8'hCC});
        for (int i = 0; i < 3; i++)
            stim_q.push_back('{8'($urandom), 8'($urandom), 8'($urandom)});

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_sclk", 40'(sclk), 40'd0);
        check_value("rst_mosi", 40'(mosi), 40'd0);
        check_value("rst_cs_n", 40'(cs_n), 40'd1);
        check_value("rst_axis", 40'(axis_data), 40'd0);
        check_value("rst_dv", 40'(data_valid), 40'd0);
        check_value("rst_tilt", 40'(tilt_dir), 40'd0);
        check_value("rst_busy", 40'(busy), 40'd0);
        #2 reset = 1'b0;

        wait_dv(10, 4000);

        // Abort a READ at bit 13 with an asynchronous reset pulse
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if ((cs_n === 1'b0) && !s_is_cfg && (s_bits == 13)) found = 1'b1;
        end
        check_value("reach_bit13", 40'(found), 40'd1);
        s_abort = 1'b1;
        reset   = 1'b1;
        #1;
        check_value("abort_cs_n", 40'(cs_n), 40'd1);
        check_value("abort_sclk", 40'(sclk), 40'd0);
        check_value("abort_busy", 40'(busy), 40'd0);
        check_value("abort_tilt", 40'(tilt_dir), 40'd0);
        exp_q.delete();
        model_clear();
        have_last = 1'b0;
        s_is_cfg  = 1'b1;
        stim_q.delete();
        stim_q.push_back('{8'h7F, 8'h01, 8'h02});
        stim_q.push_back('{8'hE8, 8'h03, 8'h04});
        stim_q.push_back('{8'h81, 8'h05, 8'h06});
        stim_q.push_back('{8'h18, 8'h07, 8'h08});
        #13 reset = 1'b0;

        wait_dv(n_dv + 4, 2000);
        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
